// File: rtl/axi_bus_pkg.sv
// axi_bus_pkg: shared constants, FSM encoding and helpers for axi_bus_arb_n.
// No ports; imported by the interfaces, the arbiter core and the top.
package axi_bus_pkg;

  localparam int ATOP_W     = 6;
  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } arb_state_e;

  // Round-robin successor of v in 0..n-1.
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/axi_bus_arb_n_if.sv
// Bus bundles for axi_bus_arb_n: flattened manager side and one subordinate side.
// axi_mgr_if: slave = arbiter view, master = managers; axi_sub_if: master = arbiter.
interface axi_mgr_if #(
  parameter int NM     = 3,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import axi_bus_pkg::*;

  logic [NM-1:0]          m_req_wt, m_gnt_wt;
  logic [NM-1:0]          m_req_rd, m_gnt_rd;
  logic [NM-1:0]          m_awvalid, m_awready;
  logic [NM*ID_W-1:0]     m_awid;
  logic [NM*ADDR_W-1:0]   m_awaddr;
  logic [NM*ATOP_W-1:0]   m_awatop;
  logic [NM-1:0]          m_wvalid, m_wlast, m_wready;
  logic [NM*DATA_W-1:0]   m_wdata;
  logic [NM*DATA_W/8-1:0] m_wstrb;
  logic [NM-1:0]          m_bvalid, m_bready;
  logic [ID_W-1:0]        m_bid;
  logic                   m_bcomp;
  logic [NM-1:0]          m_arvalid, m_arready;
  logic [NM*ID_W-1:0]     m_arid;
  logic [NM*ADDR_W-1:0]   m_araddr;
  logic [NM-1:0]          m_rvalid, m_rready;
  logic [ID_W-1:0]        m_rid;
  logic [DATA_W-1:0]      m_rdata;
  logic                   m_rlast;

  modport slave (
    input  m_req_wt, m_req_rd,
    input  m_awvalid, m_awid, m_awaddr, m_awatop,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast,
    input  m_bready, m_arvalid, m_arid, m_araddr, m_rready,
    output m_gnt_wt, m_gnt_rd, m_awready, m_wready,
    output m_bvalid, m_bid, m_bcomp, m_arready,
    output m_rvalid, m_rid, m_rdata, m_rlast
  );

  modport master (
    output m_req_wt, m_req_rd,
    output m_awvalid, m_awid, m_awaddr, m_awatop,
    output m_wvalid, m_wdata, m_wstrb, m_wlast,
    output m_bready, m_arvalid, m_arid, m_araddr, m_rready,
    input  m_gnt_wt, m_gnt_rd, m_awready, m_wready,
    input  m_bvalid, m_bid, m_bcomp, m_arready,
    input  m_rvalid, m_rid, m_rdata, m_rlast
  );
endinterface

interface axi_sub_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import axi_bus_pkg::*;

  logic                awvalid, awready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [ATOP_W-1:0]   awatop;
  logic                wvalid, wlast, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid, bready, bcomp;
  logic [ID_W-1:0]     bid;
  logic                arvalid, arready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid, rready, rlast;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output awvalid, awid, awaddr, awatop,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, arid, araddr, rready,
    input  awready, wready, bvalid, bid, bcomp,
    input  arready, rvalid, rid, rdata, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awatop,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, arid, araddr, rready,
    output awready, wready, bvalid, bid, bcomp,
    output arready, rvalid, rid, rdata, rlast
  );
endinterface

// File: rtl/axi_bus_arb_n_rr_core.sv
// arb_rr_core: one channel's round-robin grant FSM with watchdog.
// Ports: clk, rst, req[NM], done -> registered one-hot gnt[NM], tmo pulse.
module arb_rr_core
  import axi_bus_pkg::*;
#(
  parameter int NM      = 3,
  parameter int TMO_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NM-1:0] req,
  input  logic          done,
  output logic [NM-1:0] gnt,
  output logic          tmo
);
  localparam int PW = $clog2(NM);
  localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  arb_state_e    state_q, state_d;
  logic [NM-1:0] gnt_d;
  logic [PW-1:0] ptr_q, ptr_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_d, found, expire;
  int            idx;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NM; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NM) idx = idx - NM;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign expire = (TMO_CYC != 0) && (cnt_q == CMAX);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GNT;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          ptr_d      = PW'(wrap_inc(int'(win), NM));
          cnt_d      = '0;
        end
      end
      GNT: begin
        // done beats a coincident expiry
        if (done) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (expire) begin
          state_d = IDLE;
          gnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo     <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo     <= tmo_d;
    end
  end

endmodule

// File: rtl/axi_bus_arb_n.sv
// axi_bus_arb_n: NM-manager AXI arbiter/mux, independent write and read grants.
// Ports: clk, rst, mgr (manager bundle), sub (subordinate bundle), tmo_wt, tmo_rd.
module axi_bus_arb_n
  import axi_bus_pkg::*;
#(
  parameter int NM      = 3,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 1024
) (
  input  logic      clk,
  input  logic      rst,
  axi_mgr_if.slave  mgr,
  axi_sub_if.master sub,
  output logic      tmo_wt,
  output logic      tmo_rd
);
  localparam int SW = DATA_W / 8;

  logic [NM-1:0] gw, gr;
  logic          wdone, rdone;

  assign wdone = sub.bvalid & sub.bready;
  assign rdone = sub.rvalid & sub.rready & sub.rlast;

  arb_rr_core #(.NM(NM), .TMO_CYC(TMO_CYC)) u_wt (
    .clk(clk), .rst(rst), .req(mgr.m_req_wt),
    .done(wdone), .gnt(gw), .tmo(tmo_wt)
  );

  arb_rr_core #(.NM(NM), .TMO_CYC(TMO_CYC)) u_rd (
    .clk(clk), .rst(rst), .req(mgr.m_req_rd),
    .done(rdone), .gnt(gr), .tmo(tmo_rd)
  );

  assign mgr.m_gnt_wt = gw;
  assign mgr.m_gnt_rd = gr;

  // Grant is one-hot or zero; no grant leaves everything at 0.
  always_comb begin
    sub.awvalid = 1'b0;
    sub.awid    = '0;
    sub.awaddr  = '0;
    sub.awatop  = '0;
    sub.wvalid  = 1'b0;
    sub.wdata   = '0;
    sub.wstrb   = '0;
    sub.wlast   = 1'b0;
    sub.bready  = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (gw[k]) begin
        sub.awvalid = mgr.m_awvalid[k];
        sub.awid    = mgr.m_awid[k*ID_W +: ID_W];
        sub.awaddr  = mgr.m_awaddr[k*ADDR_W +: ADDR_W];
        sub.awatop  = mgr.m_awatop[k*ATOP_W +: ATOP_W];
        sub.wvalid  = mgr.m_wvalid[k];
        sub.wdata   = mgr.m_wdata[k*DATA_W +: DATA_W];
        sub.wstrb   = mgr.m_wstrb[k*SW +: SW];
        sub.wlast   = mgr.m_wlast[k];
        sub.bready  = mgr.m_bready[k];
      end
    end
  end

  always_comb begin
    sub.arvalid = 1'b0;
    sub.arid    = '0;
    sub.araddr  = '0;
    sub.rready  = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (gr[k]) begin
        sub.arvalid = mgr.m_arvalid[k];
        sub.arid    = mgr.m_arid[k*ID_W +: ID_W];
        sub.araddr  = mgr.m_araddr[k*ADDR_W +: ADDR_W];
        sub.rready  = mgr.m_rready[k];
      end
    end
  end

  assign mgr.m_awready = gw & {NM{sub.awready}};
  assign mgr.m_wready  = gw & {NM{sub.wready}};
  assign mgr.m_bvalid  = gw & {NM{sub.bvalid}};
  assign mgr.m_bid     = (|gw) ? sub.bid : '0;
  assign mgr.m_bcomp   = (|gw) ? sub.bcomp : 1'b0;
  assign mgr.m_arready = gr & {NM{sub.arready}};
  assign mgr.m_rvalid  = gr & {NM{sub.rvalid}};
  assign mgr.m_rid     = (|gr) ? sub.rid : '0;
  assign mgr.m_rdata   = (|gr) ? sub.rdata : '0;
  assign mgr.m_rlast   = (|gr) ? sub.rlast : 1'b0;

endmodule

// File: tb/tb_axi_bus_arb_n.sv
// tb_axi_bus_arb_n: directed self-checking bench for axi_bus_arb_n.
// NM=3, TMO_CYC=16; inputs driven 1 unit after posedge, outputs sampled after.
module tb_axi_bus_arb_n;
  localparam int NM = 3;
  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tmo_wt, tmo_rd;
  int   checks = 0;
  int   errors = 0;

  axi_mgr_if #(.NM(NM), .ID_W(ID_W), .ADDR_W(ADDR_W),
               .DATA_W(DATA_W)) mi ();
  axi_sub_if #(.ID_W(ID_W), .ADDR_W(ADDR_W),
               .DATA_W(DATA_W)) si ();

  axi_bus_arb_n #(
    .NM(NM), .ID_W(ID_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .TMO_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .mgr(mi), .sub(si),
    .tmo_wt(tmo_wt), .tmo_rd(tmo_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mi.m_req_wt = '0;  mi.m_req_rd = '0;
    mi.m_awvalid = '0; mi.m_awid = '0;
    mi.m_awaddr = '0;  mi.m_awatop = '0;
    mi.m_wvalid = '0;  mi.m_wdata = '0;
    mi.m_wstrb = '0;   mi.m_wlast = '0;
    mi.m_bready = '0;  mi.m_arvalid = '0;
    mi.m_arid = '0;    mi.m_araddr = '0;
    mi.m_rready = '0;
    si.awready = 0; si.wready = 0;
    si.bvalid = 0;  si.bid = '0; si.bcomp = 0;
    si.arready = 0; si.rvalid = 0; si.rid = '0;
    si.rdata = '0;  si.rlast = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({mi.m_gnt_wt, mi.m_gnt_rd} !== 6'b0) begin
      errors++;
      $display("FAIL rst_gnt got %b/%b want 0/0",
               mi.m_gnt_wt, mi.m_gnt_rd);
    end
    checks++;
    if ({si.awvalid, si.wvalid, si.bready,
         si.arvalid, si.rready} !== 5'b0) begin
      errors++;
      $display("FAIL rst_sub_vr got %b want 0",
               {si.awvalid, si.wvalid, si.bready,
                si.arvalid, si.rready});
    end
    checks++;
    if (si.awaddr !== 32'h0 || si.araddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_payload got %h/%h want 0/0",
               si.awaddr, si.araddr);
    end
    checks++;
    if ({tmo_wt, tmo_rd} !== 2'b00) begin
      errors++;
      $display("FAIL rst_tmo got %b want 00", {tmo_wt, tmo_rd});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    mi.m_awvalid = 3'b010;
    mi.m_awid    = {4'h0, 4'h5, 4'h0};
    mi.m_awaddr  = {32'h0, 32'h8000_0010, 32'h0};
    mi.m_wvalid  = 3'b010;
    mi.m_wdata   = {32'h0, 32'hCAFE_0001, 32'h0};
    mi.m_wstrb   = {4'h0, 4'hF, 4'h0};
    mi.m_wlast   = 3'b010;
    mi.m_req_wt  = 3'b010;
    tick();
    mi.m_req_wt = '0;
    si.awready = 1; si.wready = 1;
    #1;
    checks++;
    if (mi.m_gnt_wt !== 3'b010) begin
      errors++;
      $display("FAIL sw_gnt got %b want 010", mi.m_gnt_wt);
    end
    checks++;
    if (si.awvalid !== 1'b1 || si.awaddr !== 32'h8000_0010
        || si.awid !== 4'h5) begin
      errors++;
      $display("FAIL sw_aw got %b %h %h want 1 80000010 5",
               si.awvalid, si.awaddr, si.awid);
    end
    checks++;
    if (si.wdata !== 32'hCAFE_0001 || si.wstrb !== 4'hF) begin
      errors++;
      $display("FAIL sw_w got %h %h want cafe0001 f",
               si.wdata, si.wstrb);
    end
    checks++;
    if (mi.m_awready !== 3'b010 || mi.m_wready !== 3'b010) begin
      errors++;
      $display("FAIL sw_ready got %b %b want 010 010",
               mi.m_awready, mi.m_wready);
    end
    checks++;
    if (mi.m_gnt_rd !== 3'b000) begin
      errors++;
      $display("FAIL sw_rd_idle got %b want 000", mi.m_gnt_rd);
    end
    tick();
    mi.m_awvalid = '0; mi.m_wvalid = '0; mi.m_wlast = '0;
    si.awready = 0; si.wready = 0;
    mi.m_bready = 3'b101; si.bvalid = 1; si.bid = 4'h5;
    #1;
    checks++;
    if (si.bready !== 1'b0 || mi.m_bvalid !== 3'b010
        || mi.m_bid !== 4'h5) begin
      errors++;
      $display("FAIL sw_b_route got %b %b %h want 0 010 5",
               si.bready, mi.m_bvalid, mi.m_bid);
    end
    tick();
    checks++;
    if (mi.m_gnt_wt !== 3'b010) begin
      errors++;
      $display("FAIL sw_hold got %b want 010", mi.m_gnt_wt);
    end
    mi.m_bready = 3'b111;
    tick();
    si.bvalid = 0; mi.m_bready = '0;
    checks++;
    if (mi.m_gnt_wt !== 3'b000) begin
      errors++;
      $display("FAIL sw_release got %b want 000", mi.m_gnt_wt);
    end
    #1;
    checks++;
    if (mi.m_bvalid !== 3'b000 || si.bready !== 1'b0) begin
      errors++;
      $display("FAIL sw_b_idle got %b %b want 000 0",
               mi.m_bvalid, si.bready);
    end
  endtask

  task automatic test_rr_reads();
    logic [2:0] seq [7];
    seq = '{3'b001, 3'b000, 3'b010, 3'b000,
            3'b100, 3'b000, 3'b001};
    si.rvalid = 1; si.rlast = 1; si.rdata = 32'h1234_5678;
    mi.m_rready = 3'b111; mi.m_req_rd = 3'b111;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 6) mi.m_req_rd = '0;
      checks++;
      if (mi.m_gnt_rd !== seq[i] || mi.m_rvalid !== seq[i]) begin
        errors++;
        $display("FAIL rr_cyc%0d got %b/%b want %b",
                 i, mi.m_gnt_rd, mi.m_rvalid, seq[i]);
      end
    end
    tick();
    checks++;
    if (mi.m_gnt_rd !== 3'b000) begin
      errors++;
      $display("FAIL rr_end got %b want 000", mi.m_gnt_rd);
    end
    si.rvalid = 0; si.rlast = 0; mi.m_rready = '0;
  endtask

  task automatic test_ptr_wrap();
    si.bvalid = 1; mi.m_bready = 3'b111;
    mi.m_req_wt = 3'b101;
    tick();
    checks++;
    if (mi.m_gnt_wt !== 3'b100) begin
      errors++;
      $display("FAIL pw_first got %b want 100", mi.m_gnt_wt);
    end
    mi.m_req_wt = 3'b001;
    tick();
    checks++;
    if (mi.m_gnt_wt !== 3'b000) begin
      errors++;
      $display("FAIL pw_dead got %b want 000", mi.m_gnt_wt);
    end
    tick();
    checks++;
    if (mi.m_gnt_wt !== 3'b001) begin
      errors++;
      $display("FAIL pw_second got %b want 001", mi.m_gnt_wt);
    end
    mi.m_req_wt = '0;
    tick();
    si.bvalid = 0; mi.m_bready = '0;
  endtask

  task automatic test_burst();
    logic [DATA_W-1:0] beat;
    mi.m_req_rd = 3'b100; mi.m_arvalid = 3'b100;
    mi.m_araddr = {32'h0000_4000, 32'h0, 32'h0};
    si.arready = 1; si.rvalid = 1; si.rlast = 0;
    mi.m_rready = 3'b100;
    tick();
    mi.m_req_rd = '0;
    #1;
    checks++;
    if (mi.m_gnt_rd !== 3'b100 || si.araddr !== 32'h4000
        || mi.m_arready !== 3'b100) begin
      errors++;
      $display("FAIL bu_ar got %b %h %b want 100 4000 100",
               mi.m_gnt_rd, si.araddr, mi.m_arready);
    end
    for (int b = 1; b <= 3; b++) begin
      beat = DATA_W'(b);
      si.rdata = beat;
      #1;
      checks++;
      if (mi.m_rdata !== beat || mi.m_rlast !== 1'b0) begin
        errors++;
        $display("FAIL bu_beat%0d got %h %b want %h 0",
                 b, mi.m_rdata, mi.m_rlast, beat);
      end
      tick();
      mi.m_arvalid = '0; si.arready = 0;
      checks++;
      if (mi.m_gnt_rd !== 3'b100) begin
        errors++;
        $display("FAIL bu_hold%0d got %b want 100",
                 b, mi.m_gnt_rd);
      end
    end
    si.rdata = 32'h4; si.rlast = 1;
    tick();
    checks++;
    if (mi.m_gnt_rd !== 3'b000) begin
      errors++;
      $display("FAIL bu_release got %b want 000", mi.m_gnt_rd);
    end
    si.rvalid = 0; si.rlast = 0; mi.m_rready = '0;
  endtask

  task automatic test_timeout();
    int early;
    mi.m_req_wt = 3'b011; mi.m_bready = 3'b011; si.bvalid = 0;
    tick();
    mi.m_req_wt = 3'b001;
    checks++;
    if (mi.m_gnt_wt !== 3'b010 || tmo_wt !== 1'b0) begin
      errors++;
      $display("FAIL to_gnt got %b %b want 010 0",
               mi.m_gnt_wt, tmo_wt);
    end
    early = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (tmo_wt !== 1'b0 || mi.m_gnt_wt !== 3'b010) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL to_early got %0d bad cycles want 0", early);
    end
    tick();
    checks++;
    if (tmo_wt !== 1'b1 || mi.m_gnt_wt !== 3'b000
        || tmo_rd !== 1'b0) begin
      errors++;
      $display("FAIL to_fire got tmo %b gnt %b rd %b want 1 000 0",
               tmo_wt, mi.m_gnt_wt, tmo_rd);
    end
    tick();
    mi.m_req_wt = '0;
    checks++;
    if (tmo_wt !== 1'b0 || mi.m_gnt_wt !== 3'b001) begin
      errors++;
      $display("FAIL to_next got tmo %b gnt %b want 0 001",
               tmo_wt, mi.m_gnt_wt);
    end
    si.bvalid = 1;
    tick();
    checks++;
    if (mi.m_gnt_wt !== 3'b000) begin
      errors++;
      $display("FAIL to_done got %b want 000", mi.m_gnt_wt);
    end
    si.bvalid = 0; mi.m_bready = '0;
  endtask

  task automatic test_reset_mid();
    mi.m_req_rd = 3'b010; mi.m_arvalid = 3'b010;
    si.rvalid = 1; si.rlast = 0; mi.m_rready = 3'b010;
    tick();
    mi.m_req_rd = '0;
    checks++;
    if (mi.m_gnt_rd !== 3'b010) begin
      errors++;
      $display("FAIL rm_gnt got %b want 010", mi.m_gnt_rd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mi.m_gnt_rd !== 3'b000 || mi.m_rvalid !== 3'b000
        || si.rready !== 1'b0 || si.arvalid !== 1'b0) begin
      errors++;
      $display("FAIL rm_async got %b %b %b %b want 000 000 0 0",
               mi.m_gnt_rd, mi.m_rvalid, si.rready, si.arvalid);
    end
    tick();
    rst = 1'b0;
    si.rvalid = 0; mi.m_arvalid = '0; mi.m_rready = '0;
    mi.m_req_rd = 3'b111;
    tick();
    mi.m_req_rd = '0;
    checks++;
    if (mi.m_gnt_rd !== 3'b001) begin
      errors++;
      $display("FAIL rm_after got %b want 001", mi.m_gnt_rd);
    end
    si.rvalid = 1; si.rlast = 1; mi.m_rready = 3'b001;
    tick();
    si.rvalid = 0; si.rlast = 0; mi.m_rready = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout sim still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_rr_reads();
    test_ptr_wrap();
    test_burst();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_bus_arb_n.md
# axi_bus_arb_n

Parametrised N-manager AXI bus arbiter/multiplexer, the successor of the fixed two-manager bus top. Sits between NM bus managers (dcache, uart, icache, DMA, …) and the single shared AXI subordinate port toward the memory controller. Adds round-robin fairness, grant-gated ready/valid routing instead of broadcast, and a per-channel watchdog that recovers a hung grant. Write and read channels arbitrate independently.

## Interface
Parameters:
- NM, 3, number of managers (2..8)
- ID_W, 4, AXI id width
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width DATA_W/8
- TMO_CYC, 1024, watchdog limit in cycles; 0 disables

Ports. Manager-side buses are flattened, manager k in slice k:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_req_wt / m_gnt_wt  in / out  NM  write request / registered write grant
- m_req_rd / m_gnt_rd  in / out  NM  read request / registered read grant
- m_awvalid, m_awid, m_awaddr, m_awatop  in  NM, NM*ID_W, NM*ADDR_W, NM*6  write address
- m_awready  out  NM
- m_wvalid, m_wdata, m_wstrb, m_wlast  in  NM, NM*DATA_W, NM*DATA_W/8, NM  write data
- m_wready  out  NM
- m_bvalid, m_bid, m_bcomp  out  NM, ID_W, 1  write response (id/comp shared)
- m_bready  in  NM
- m_arvalid, m_arid, m_araddr  in  NM, NM*ID_W, NM*ADDR_W  read address
- m_arready  out  NM
- m_rvalid  out  NM; m_rid, m_rdata, m_rlast  out  ID_W, DATA_W, 1 (shared)
- m_rready  in  NM
- awvalid..wlast, bready, arvalid, araddr, arid, rready  out  subordinate side, same widths as one manager slice
- awready, wready, bvalid, bid, bcomp, arready, rvalid, rid, rdata, rlast  in  subordinate side
- tmo_wt, tmo_rd  out  1  one-cycle watchdog pulse

## Operation
- Per channel FSM: IDLE -> GNT -> IDLE.
- IDLE: if any req bit set, pick first requester at or after rr pointer (wrapping at NM-1 -> 0); load one-hot grant, go GNT; pointer <- winner+1 mod NM.
- GNT: subordinate outputs driven from granted slice; subordinate ready/valid returned only to granted manager; all other managers see ready=0, valid=0.
- Write done: bvalid & bready. Read done: rvalid & rready & rlast. On done: grant cleared, -> IDLE.
- Watchdog: counter clears on grant, increments each GNT cycle; at TMO_CYC-1 without done, grant cleared, tmo pulse, -> IDLE.
- IDLE or no grant: all subordinate-side valid/ready outputs 0, payload 0.
- Managers hold req until gnt; req dropped in GNT does not release the grant.

## Timing
- Reset: all gnt, m_* ready/valid, subordinate valid/ready, payloads, tmo = 0; rr pointer 0; FSM IDLE; counter 0. Async assert, sync release.
- req at cycle t (IDLE) -> gnt high t+1; muxing valid from t+1 (pure combinational from registered grant).
- done at cycle t -> gnt low t+1, FSM IDLE t+1; next grant earliest t+2 (one dead cycle, deliberate).
- done and watchdog expiry in same cycle: done wins, no tmo pulse.
- Single requester re-requests: re-granted, pointer wraps past itself.
- rst mid-transaction: grants dropped immediately; subordinate-side transaction is abandoned (system-level reset expected).

## Structure
- Package axi_bus_pkg: width constants, FSM state encoding (IDLE=0, GNT=1), atop width 6.
- Sub-module arb_rr_core (NM, TMO_CYC): FSM, rr pointer, one-hot grant, watchdog; instantiated twice (write, read). Top holds only muxes and grant gating.

## Test plan
- NM=3, only m1 requests write, single beat: gnt_wt=3'b010 at t+1, awaddr=0x8000_0010 reaches subordinate, bvalid routed only to m1, gnt drops cycle after b handshake.
- All three request reads continuously: grants 001,010,100,001 with one dead cycle between each.
- Pointer at 2, m0 and m2 request: m2 granted first, then m0.
- Read of 4 beats: grant held through beats 1-3 (rlast=0), released after rlast handshake only.
- TMO_CYC=16, subordinate never asserts bvalid: tmo_wt pulses at grant+16, gnt cleared, next requester granted.
- rst asserted during active read burst: all gnt and valid outputs 0 same cycle; after release first grant goes to m0.
